// File: rtl/fsm_input_conditioner.sv
// Synchronizes and debounces raw switches and the start button for the control FSM.
// x updates atomically; start and x_chg are registered single-cycle pulses.
module fsm_input_conditioner #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned CNT_W     = 20
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] sw_raw,
  input  logic       btn_raw,
  output logic [1:0] x,
  output logic       start,
  output logic       x_chg
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sw_s1_q, sw_s2_q, sw_s3_q, x_q;
  logic [CNT_W-1:0] sw_cnt_q;
  logic             btn_s1_q, btn_s2_q, btn_s3_q, btn_stable_q;
  logic [CNT_W-1:0] btn_cnt_q;
  logic             start_q, x_chg_q;

  logic sw_restart, sw_accept, btn_restart, btn_accept;

  // A channel restarts on any synchronized edge or when it already matches the stable value.
  always_comb begin
    sw_restart  = (sw_s2_q != sw_s3_q) || (sw_s2_q == x_q);
    sw_accept   = !sw_restart && (sw_cnt_q == CntMax);
    btn_restart = (btn_s2_q != btn_s3_q) || (btn_s2_q == btn_stable_q);
    btn_accept  = !btn_restart && (btn_cnt_q == CntMax);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      sw_s3_q      <= '0;
      x_q          <= '0;
      sw_cnt_q     <= '0;
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      btn_s3_q     <= 1'b0;
      btn_stable_q <= 1'b0;
      btn_cnt_q    <= '0;
      start_q      <= 1'b0;
      x_chg_q      <= 1'b0;
    end else begin
      sw_s1_q  <= sw_raw;
      sw_s2_q  <= sw_s1_q;
      sw_s3_q  <= sw_s2_q;
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
      btn_s3_q <= btn_s2_q;

      if (sw_restart) begin
        sw_cnt_q <= '0;
      end else if (sw_accept) begin
        x_q      <= sw_s2_q;
        sw_cnt_q <= '0;
      end else begin
        sw_cnt_q <= sw_cnt_q + CNT_W'(1);
      end

      if (btn_restart) begin
        btn_cnt_q <= '0;
      end else if (btn_accept) begin
        btn_stable_q <= btn_s2_q;
        btn_cnt_q    <= '0;
      end else begin
        btn_cnt_q <= btn_cnt_q + CNT_W'(1);
      end

      x_chg_q <= sw_accept;
      // Only an accepted press pulses; an accepted release is silent.
      start_q <= btn_accept && btn_s2_q;
    end
  end

  assign x     = x_q;
  assign start = start_q;
  assign x_chg = x_chg_q;

endmodule
